// File: rtl/switch_debounce_bank.sv
// switch_debounce_bank: per-switch 2-flop sync, debounce filter and press/release/hold pulses
// Ports: i_Clk clock; i_Reset sync active-high reset; i_Switches raw levels (1 = pressed);
//   o_Switches debounced levels; o_Pressed/o_Released 1-cycle edge pulses;
//   o_Held 1-cycle long-press pulse, only when SWITCH_HOLD_EN is defined (else tied 0).
module switch_debounce_bank #(
  parameter int g_NUM_SWITCHES   = 4,
  parameter int g_DEBOUNCE_LIMIT = 250000
`ifdef SWITCH_HOLD_EN
  , parameter int g_HOLD_LIMIT   = 25000000 * 3
`endif
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic [g_NUM_SWITCHES-1:0] i_Switches,
  output logic [g_NUM_SWITCHES-1:0] o_Switches,
  output logic [g_NUM_SWITCHES-1:0] o_Pressed,
  output logic [g_NUM_SWITCHES-1:0] o_Released,
  output logic [g_NUM_SWITCHES-1:0] o_Held
);
  localparam int CW = $clog2(g_DEBOUNCE_LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(g_DEBOUNCE_LIMIT - 1);
  logic [g_NUM_SWITCHES-1:0] sync1_q, sync2_q, sw_q, sw_d;
  logic [g_NUM_SWITCHES-1:0] pressed_q, pressed_d, released_q, released_d, done;
  logic [CW-1:0] cnt_q [g_NUM_SWITCHES];
  logic [CW-1:0] cnt_d [g_NUM_SWITCHES];
  // A level is accepted on the increment that would reach the limit; the pulse registers alongside it.
  always_comb begin
    for (int i = 0; i < g_NUM_SWITCHES; i++) begin
      done[i]       = (sync2_q[i] != sw_q[i]) && (cnt_q[i] == LAST);
      cnt_d[i]      = (sync2_q[i] == sw_q[i] || done[i]) ? '0 : cnt_q[i] + 1'b1;
      sw_d[i]       = done[i] ? sync2_q[i] : sw_q[i];
      pressed_d[i]  = done[i] & sync2_q[i];
      released_d[i] = done[i] & ~sync2_q[i];
    end
  end
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sw_q       <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      cnt_q      <= '{default: '0};
    end else begin
      sync1_q    <= i_Switches;
      sync2_q    <= sync1_q;
      sw_q       <= sw_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      cnt_q      <= cnt_d;
    end
  end
  assign o_Switches = sw_q;
  assign o_Pressed  = pressed_q;
  assign o_Released = released_q;
`ifdef SWITCH_HOLD_EN
  localparam logic [31:0] HL = 32'(g_HOLD_LIMIT);
  logic [31:0] hold_q [g_NUM_SWITCHES];
  logic [31:0] hold_d [g_NUM_SWITCHES];
  logic [g_NUM_SWITCHES-1:0] held_q, held_d;
  // Saturating at the limit gives exactly one pulse per press; release clears and re-arms.
  always_comb begin
    for (int i = 0; i < g_NUM_SWITCHES; i++) begin
      hold_d[i] = !sw_q[i] ? '0 : (hold_q[i] == HL ? hold_q[i] : hold_q[i] + 1);
      held_d[i] = sw_q[i] && (hold_q[i] == HL - 1);
    end
  end
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      hold_q <= '{default: '0};
      held_q <= '0;
    end else begin
      hold_q <= hold_d;
      held_q <= held_d;
    end
  end
  assign o_Held = held_q;
`else
  assign o_Held = '0;
`endif
endmodule

// File: tb/tb_switch_debounce_bank.sv
// tb_switch_debounce_bank: scoreboard bench for switch_debounce_bank (limit 4, hold 10)
module tb_switch_debounce_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] sw_in = 4'hF;
  logic [3:0] o_sw, o_pr, o_rl, o_hd;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int          cyc;
    logic [15:0] v;
  } ev_t;
  ev_t sb[$];
  switch_debounce_bank #(
    .g_NUM_SWITCHES(4),
    .g_DEBOUNCE_LIMIT(4)
`ifdef SWITCH_HOLD_EN
    , .g_HOLD_LIMIT(10)
`endif
  ) dut (
    .i_Clk(clk),
    .i_Reset(rst),
    .i_Switches(sw_in),
    .o_Switches(o_sw),
    .o_Pressed(o_pr),
    .o_Released(o_rl),
    .o_Held(o_hd)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_ev(input int dly, input logic [3:0] s, input logic [3:0] p,
                           input logic [3:0] r, input logic [3:0] h);
    ev_t e;
    e.cyc = cyc + dly;
    e.v = {s, p, r, h};
    sb.push_back(e);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h want %h", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    ev_t e;
    if (rst && cyc >= 1) chk("reset_outputs", {16'h0, o_sw, o_pr, o_rl, o_hd}, 32'h0);
    else if (|{o_pr, o_rl, o_hd}) begin
      if (sb.size() == 0) chk("unexpected_pulse", {16'h0, o_sw, o_pr, o_rl, o_hd}, 32'h0);
      else begin
        e = sb.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("event_outputs", {16'h0, o_sw, o_pr, o_rl, o_hd}, {16'h0, e.v});
      end
    end
  end
  initial begin
    tick(3);
    rst = 1'b0;
    expect_ev(6, 4'hF, 4'hF, 4'h0, 4'h0);
    tick(9);
    sw_in = 4'h0;
    expect_ev(6, 4'h0, 4'h0, 4'hF, 4'h0);
    tick(8);
    sw_in = 4'b0001;
    expect_ev(6, 4'b0001, 4'b0001, 4'h0, 4'h0);
    tick(8);
    sw_in = 4'b0011;
    tick(3);
    sw_in = 4'b0001;
    tick(1);
    sw_in = 4'b0011;
    expect_ev(6, 4'b0011, 4'b0010, 4'h0, 4'h0);
    tick(8);
    sw_in = 4'b0010;
    expect_ev(6, 4'b0010, 4'h0, 4'b0001, 4'h0);
    tick(8);
    sw_in = 4'b1110;
    expect_ev(6, 4'b1110, 4'b1100, 4'h0, 4'h0);
    tick(8);
    sw_in = 4'h0;
    expect_ev(6, 4'h0, 4'h0, 4'b1110, 4'h0);
    tick(8);
    sw_in = 4'b0001;
    tick(4);
    rst = 1'b1;
    tick(2);
    sw_in = 4'h0;
    tick(1);
    rst = 1'b0;
    tick(12);
    sw_in = 4'b0001;
    expect_ev(6, 4'b0001, 4'b0001, 4'h0, 4'h0);
`ifdef SWITCH_HOLD_EN
    expect_ev(16, 4'b0001, 4'h0, 4'h0, 4'b0001);
`endif
    tick(20);
    sw_in = 4'h0;
    expect_ev(6, 4'h0, 4'h0, 4'b0001, 4'h0);
    tick(10);
    chk("final_level", {28'h0, o_sw}, 32'h0);
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
